uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
- Transmit sequencer for the UART.
- Owns the UART clock generator: programs its divider, gates its enable, and uses its falling_edge tick as the bit boundary.
- Serialises bytes on txd as start bit, 8 data bits (LSB first), optional parity bit, then 1 stop bit.
- Sits between the UART register/FIFO front-end (valid/ready byte stream, divider config strobe) and the clock generator plus TX pad.

Parameters:
- RESET_DIV, 8'd0, divider programmed into the clock generator automatically after reset.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- cfg_div_valid  input  1  one-cycle strobe: new divider on cfg_div.
- cfg_div  input  8  divider value; bit period T = 2*(div+1) clk cycles.
- tx_data  input  8  byte to send.
- tx_parity_en  input  1  append parity bit; sampled at accept.
- tx_parity_odd  input  1  1 = odd parity, 0 = even; sampled at accept.
- tx_valid  input  1  byte offered.
- tx_ready  output  1  controller can accept a byte this cycle.
- tx_busy  output  1  frame in progress (any state other than IDLE/CONFIG).
- txd  output  1  serial line, registered, idle high.
- gen_en  output  1  clock generator enable.
- gen_div_valid  output  1  clock generator divider load strobe.
- gen_div  output  8  divider value to the clock generator.
- gen_falling_edge  input  1  clock generator falling-edge tick.

Behaviour:
- Reset values: txd=1, tx_busy=0, gen_div_valid=0, gen_div=RESET_DIV, pending_div=RESET_DIV, div_pending=1.
- Reset values (cont.): state=CONFIG, so the generator is programmed right after reset.
- Because state resets to CONFIG, gen_div_valid=1 in the first cycle after reset release; tx_ready=0 during that cycle.
- Divider capture: cfg_div_valid in any state loads pending_div<=cfg_div and sets div_pending.
- Divider capture (cont.): a later strobe before it is applied overwrites the earlier one (last value wins).
- States: IDLE, CONFIG, START, DATA, PARITY, STOP.
- IDLE: txd=1; tx_ready = ~div_pending.
  - If div_pending: go to CONFIG.
  - Else if tx_valid: accept. Latch the shift register, parity_en and parity_odd; go to START.
  - The accept cycle is the one where tx_valid && tx_ready.
- CONFIG (1 cycle): gen_div_valid=1, gen_div=pending_div, gen_en=0; clear div_pending; go to IDLE.
  - If cfg_div_valid arrives in the same cycle, the new value is captured and div_pending stays set.
  - That value is applied by a second CONFIG pass.
- gen_en is combinational: (state in START/DATA/PARITY/STOP) or accept. The generator therefore starts counting in the accept cycle.
- txd transitions occur in the cycle after the cycle where gen_falling_edge=1 is observed.
- START: txd=0 from cycle accept+1; on tick, go to DATA with bit_cnt=0.
- DATA: txd=shift[0]. On each tick, shift right and increment the 3-bit bit_cnt.
  - On the tick with bit_cnt==7: go to PARITY if parity_en, else STOP.
- PARITY: txd = XOR(data) XOR parity_odd; on tick, go to STOP.
- STOP: txd=1; on tick, go to IDLE.
- Bit timing:
  - Every start, data and parity bit lasts exactly T cycles.
  - The stop bit lasts T+1 minimum, because IDLE takes one cycle before the next accept.
- gen_falling_edge in IDLE/CONFIG is ignored.
- tx_data, parity_en and parity_odd changes after accept have no effect on the frame in flight.
- A divider strobe mid-frame does not disturb the frame. It is applied after STOP, before the next accept.
- Reset asserted mid-frame: all state is returned to reset values immediately; txd goes high asynchronously.

Test Plan:
- Reset release with RESET_DIV=3 -> gen_div_valid=1, gen_div=3 for exactly 1 cycle, then tx_ready=1 with no frame sent.
- cfg_div=0, send 0xA5, no parity -> txd = 0,1,0,1,0,0,1,0,1,1, each bit 2 cycles; tx_busy high for the frame; tx_ready returns after stop.
- cfg_div=4, send 0x07, even parity -> parity bit=1; every bit exactly 10 cycles, measured edge-to-edge on txd and by gen_falling_edge spacing.
- Same with odd parity on 0x07 -> parity bit=0; frame is 11 bits long.
- tx_valid held high with 0x55 then 0xAA, div=1 -> back-to-back frames; stop bit is 5 cycles, all other bits 4; the second frame starts immediately.
- cfg_div_valid=9 during DATA of a div=0 frame -> frame completes at 2-cycle bits; CONFIG loads 9; next frame uses 20-cycle bits.
- rst_n pulsed low mid-DATA -> txd=1, tx_busy=0 immediately; after release the block reprograms the divider and accepts the next byte normally.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: programs the clock generator divider and serialises
// start / 8 data (LSB first) / optional parity / stop bits on txd.
module uart_tx_ctrl #(
    parameter logic [7:0] RESET_DIV = 8'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_div_valid,
    input  logic [7:0] cfg_div,
    input  logic [7:0] tx_data,
    input  logic       tx_parity_en,
    input  logic       tx_parity_odd,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       txd,
    output logic       gen_en,
    output logic       gen_div_valid,
    output logic [7:0] gen_div,
    input  logic       gen_falling_edge
);

    typedef enum logic [2:0] {
        IDLE,
        CONFIG,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t     state, state_nx;
    logic [7:0] shift, shift_nx;
    logic [2:0] bit_cnt, bit_cnt_nx;
    logic       par_en_q;
    logic       par_bit_q;
    logic [7:0] pending_div;
    logic       div_pending;
    logic       accept;
    logic       txd_nx;

    always_comb begin
        state_nx   = state;
        shift_nx   = shift;
        bit_cnt_nx = bit_cnt;
        accept     = 1'b0;
        tx_ready   = 1'b0;
        txd_nx     = 1'b1;
        case (state)
            IDLE: begin
                tx_ready = ~div_pending;
                if (div_pending) begin
                    state_nx = CONFIG;
                end else if (tx_valid) begin
                    accept   = 1'b1;
                    shift_nx = tx_data;
                    state_nx = START;
                end
            end
            CONFIG: state_nx = IDLE;
            START: begin
                if (gen_falling_edge) begin
                    state_nx   = DATA;
                    bit_cnt_nx = 3'd0;
                end
            end
            DATA: begin
                if (gen_falling_edge) begin
                    shift_nx   = {1'b0, shift[7:1]};
                    bit_cnt_nx = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_nx = par_en_q ? PARITY : STOP;
                    end
                end
            end
            PARITY: if (gen_falling_edge) state_nx = STOP;
            STOP:   if (gen_falling_edge) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // txd is registered, so it is driven from the level of the state being entered
        case (state_nx)
            START:   txd_nx = 1'b0;
            DATA:    txd_nx = shift_nx[0];
            PARITY:  txd_nx = par_bit_q;
            default: txd_nx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CONFIG;
            shift     <= 8'd0;
            bit_cnt   <= 3'd0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            txd       <= 1'b1;
        end else begin
            state   <= state_nx;
            shift   <= shift_nx;
            bit_cnt <= bit_cnt_nx;
            txd     <= txd_nx;
            if (accept) begin
                par_en_q  <= tx_parity_en;
                par_bit_q <= (^tx_data) ^ tx_parity_odd;
            end
        end
    end

    // A strobe always wins over the CONFIG clear so a same-cycle update forces another pass
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_div <= RESET_DIV;
            div_pending <= 1'b1;
        end else if (cfg_div_valid) begin
            pending_div <= cfg_div;
            div_pending <= 1'b1;
        end else if (state == CONFIG) begin
            div_pending <= 1'b0;
        end
    end

    assign tx_busy       = (state == START) || (state == DATA) ||
                           (state == PARITY) || (state == STOP);
    assign gen_en        = tx_busy || accept;
    assign gen_div_valid = (state == CONFIG) && rst_n;
    assign gen_div       = pending_div;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with a behavioural clock generator model
// that emits a registered falling-edge tick every 2*(div+1) enabled cycles.
module tb_uart_tx_ctrl;

    localparam int LOGN = 4096;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_div_valid = 1'b0;
    logic [7:0] cfg_div = 8'd0;
    logic [7:0] tx_data = 8'd0;
    logic       tx_parity_en = 1'b0;
    logic       tx_parity_odd = 1'b0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx_busy;
    logic       txd;
    logic       gen_en;
    logic       gen_div_valid;
    logic [7:0] gen_div;
    logic       gen_falling_edge;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic       txd_log   [LOGN];
    logic       fe_log    [LOGN];
    logic       busy_log  [LOGN];
    logic       ready_log [LOGN];
    logic       dv_log    [LOGN];
    logic [7:0] div_log   [LOGN];

    logic [7:0] m_div = 8'd0;
    int         m_cnt = 0;
    logic       m_fe = 1'b0;

    logic        dec_ok;
    logic [10:0] dec_bits;
    logic [10:0] dec_stable;
    int          dec_c0, dec_end, dec_wmin, dec_wmax;

    uart_tx_ctrl #(.RESET_DIV(8'd3)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_div_valid    (cfg_div_valid),
        .cfg_div          (cfg_div),
        .tx_data          (tx_data),
        .tx_parity_en     (tx_parity_en),
        .tx_parity_odd    (tx_parity_odd),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .tx_busy          (tx_busy),
        .txd              (txd),
        .gen_en           (gen_en),
        .gen_div_valid    (gen_div_valid),
        .gen_div          (gen_div),
        .gen_falling_edge (gen_falling_edge)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Clock generator model
    always @(posedge clk) begin
        if (gen_div_valid) m_div <= gen_div;
        if (!gen_en) begin
            m_cnt <= 0;
            m_fe  <= 1'b0;
        end else if (m_cnt >= 2 * (int'(m_div) + 1) - 1) begin
            m_cnt <= 0;
            m_fe  <= 1'b1;
        end else begin
            m_cnt <= m_cnt + 1;
            m_fe  <= 1'b0;
        end
    end
    assign gen_falling_edge = m_fe;

    always @(negedge clk) begin
        if (cyc < LOGN) begin
            txd_log[cyc]   = txd;
            fe_log[cyc]    = gen_falling_edge;
            busy_log[cyc]  = tx_busy;
            ready_log[cyc] = tx_ready;
            dv_log[cyc]    = gen_div_valid;
            div_log[cyc]   = gen_div;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic program_div(input logic [7:0] d);
        @(negedge clk);
        cfg_div_valid = 1'b1;
        cfg_div = d;
        @(negedge clk);
        cfg_div_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic pe, input logic po, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        tx_data = b; tx_parity_en = pe; tx_parity_odd = po; tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        acc = cyc;
        total++;
        if (n >= 500) begin
            bad++;
            $display("FAIL send_accept tx_ready=%b never 1 for byte %02h", tx_ready, b);
        end
        @(posedge clk);
        #1;
        tx_valid = 1'b0; tx_data = ~b; tx_parity_en = ~pe; tx_parity_odd = ~po;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (tx_busy === 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 3000) begin
            bad++;
            $display("FAIL wait_idle tx_busy=%b still high after %0d cycles", tx_busy, n);
        end
        repeat (3) @(negedge clk);
    endtask

    // Splits the logged txd into bits using the generator ticks as boundaries.
    task automatic decode(input int from, input int nb, input int wfirst);
        int k, s, t, prev;
        dec_ok = 1'b0; dec_bits = '0; dec_stable = '0;
        dec_wmin = 1 << 30; dec_wmax = 0; dec_c0 = -1; dec_end = -1;
        k = from;
        while (k < from + 40 && k < LOGN && txd_log[k] !== 1'b0) k++;
        if (k >= from + 40 || k >= LOGN) return;
        dec_c0 = k;
        prev = k - 1;
        for (int b = 0; b < nb; b++) begin
            s = prev + 1;
            t = s;
            while (t < LOGN && t < s + 300 && fe_log[t] !== 1'b1) t++;
            if (t >= LOGN || t >= s + 300) return;
            dec_bits[b] = txd_log[s];
            dec_stable[b] = 1'b1;
            for (int q = s; q <= t; q++) if (txd_log[q] !== txd_log[s]) dec_stable[b] = 1'b0;
            if (b >= wfirst) begin
                if (t - s + 1 < dec_wmin) dec_wmin = t - s + 1;
                if (t - s + 1 > dec_wmax) dec_wmax = t - s + 1;
            end
            prev = t;
        end
        dec_end = prev;
        dec_ok = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (txd !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs got txd=%b busy=%b ready=%b exp 1 0 0", txd, tx_busy, tx_ready);
        end
        total++;
        if (gen_div_valid !== 1'b0 || gen_div !== 8'd3 || gen_en !== 1'b0) begin
            bad++;
            $display("FAIL reset_gen got dv=%b div=%0d en=%b exp 0 3 0", gen_div_valid, gen_div, gen_en);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (gen_div_valid !== 1'b1 || gen_div !== 8'd3 || tx_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_config got dv=%b div=%0d ready=%b exp 1 3 0", gen_div_valid, gen_div, tx_ready);
        end
        @(negedge clk);
        total++;
        if (gen_div_valid !== 1'b0 || tx_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_idle got dv=%b ready=%b exp 0 1", gen_div_valid, tx_ready);
        end
        repeat (5) @(negedge clk);
        total++;
        if (txd !== 1'b1 || tx_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_noframe got txd=%b busy=%b exp 1 0", txd, tx_busy);
        end
    endtask

    task automatic test_a5();
        int acc;
        program_div(8'd0);
        send(8'hA5, 1'b0, 1'b0, acc);
        wait_idle();
        decode(acc, 10, 0);
        total++;
        if (dec_ok !== 1'b1 || dec_c0 !== acc + 1) begin
            bad++;
            $display("FAIL a5_start got ok=%b start=%0d exp ok=1 start=%0d", dec_ok, dec_c0, acc + 1);
        end
        total++;
        if (dec_bits[9:0] !== 10'b1_1010_0101_0 || dec_stable[9:0] !== 10'h3FF) begin
            bad++;
            $display("FAIL a5_bits got=%b stable=%b exp=1101001010", dec_bits[9:0], dec_stable[9:0]);
        end
        total++;
        if (dec_wmin !== 2 || dec_wmax !== 2) begin
            bad++;
            $display("FAIL a5_width got min=%0d max=%0d exp 2", dec_wmin, dec_wmax);
        end
        total++;
        if (dec_end < 0 || busy_log[acc + 1] !== 1'b1 || busy_log[dec_end] !== 1'b1 ||
            busy_log[dec_end + 1] !== 1'b0 || ready_log[dec_end + 1] !== 1'b1) begin
            bad++;
            $display("FAIL a5_busy_ready got busy=%b%b%b ready_after=%b exp busy=110 ready_after=1",
                     busy_log[acc + 1], busy_log[dec_end], busy_log[dec_end + 1], ready_log[dec_end + 1]);
        end
    endtask

    task automatic test_parity();
        int acc, k, j, run0, run1;
        logic par_exp, odd;
        logic [10:0] exp_bits;
        for (int i = 0; i < 2; i++) begin
            odd = (i == 1);
            par_exp = odd ? 1'b0 : 1'b1;
            exp_bits = {1'b1, par_exp, 8'h07, 1'b0};
            program_div(8'd4);
            send(8'h07, 1'b1, odd, acc);
            wait_idle();
            decode(acc, 11, 0);
            total++;
            if (dec_ok !== 1'b1 || dec_bits !== exp_bits || dec_stable !== 11'h7FF) begin
                bad++;
                $display("FAIL parity_bits odd=%b got=%b stable=%b exp=%b", odd, dec_bits, dec_stable, exp_bits);
            end
            total++;
            if (dec_wmin !== 10 || dec_wmax !== 10 || dec_end - dec_c0 + 1 !== 110) begin
                bad++;
                $display("FAIL parity_tick_width odd=%b got min=%0d max=%0d len=%0d exp 10 10 110",
                         odd, dec_wmin, dec_wmax, dec_end - dec_c0 + 1);
            end
            k = (dec_c0 < 0) ? 0 : dec_c0;
            while (k < LOGN - 1 && txd_log[k] === 1'b0) k++;
            run0 = k - dec_c0;
            j = k;
            while (k < LOGN - 1 && txd_log[k] === 1'b1) k++;
            run1 = k - j;
            total++;
            if (run0 !== 10 || run1 !== 30) begin
                bad++;
                $display("FAIL parity_txd_edges odd=%b got start=%0d ones=%0d exp 10 30", odd, run0, run1);
            end
            total++;
            if (dec_end < 0 || txd_log[dec_end + 1] !== 1'b1 || busy_log[dec_end + 1] !== 1'b0) begin
                bad++;
                $display("FAIL parity_end odd=%b got txd=%b busy=%b exp 1 0", odd, txd_log[dec_end + 1], busy_log[dec_end + 1]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc1, acc2, n, end1, k, ones;
        program_div(8'd1);
        @(negedge clk);
        tx_data = 8'h55; tx_parity_en = 1'b0; tx_parity_odd = 1'b0; tx_valid = 1'b1;
        n = 0;
        while (tx_ready !== 1'b1 && n < 500) begin @(negedge clk); n++; end
        acc1 = cyc;
        @(posedge clk);
        #1;
        tx_data = 8'hAA;
        n = 0;
        @(negedge clk);
        while (tx_ready !== 1'b1 && n < 500) begin @(negedge clk); n++; end
        acc2 = cyc;
        total++;
        if (n >= 500) begin
            bad++;
            $display("FAIL b2b_accept tx_ready=%b never 1 for second byte", tx_ready);
        end
        @(posedge clk);
        #1;
        tx_valid = 1'b0; tx_data = 8'h00;
        wait_idle();
        decode(acc1, 10, 0);
        end1 = dec_end;
        total++;
        if (dec_ok !== 1'b1 || dec_bits[9:0] !== 10'b1_0101_0101_0 || dec_wmin !== 4 || dec_wmax !== 4) begin
            bad++;
            $display("FAIL b2b_frame1 got bits=%b min=%0d max=%0d exp bits=1010101010 width 4",
                     dec_bits[9:0], dec_wmin, dec_wmax);
        end
        total++;
        if (acc2 !== end1 + 1) begin
            bad++;
            $display("FAIL b2b_second_accept got cycle=%0d exp=%0d", acc2, end1 + 1);
        end
        decode(acc2, 10, 1);
        total++;
        if (dec_ok !== 1'b1 || dec_c0 !== acc2 + 1 || dec_bits[9:0] !== 10'b1_1010_1010_0 ||
            dec_stable[9:0] !== 10'h3FF || dec_wmin !== 4 || dec_wmax !== 4) begin
            bad++;
            $display("FAIL b2b_frame2 got start=%0d bits=%b min=%0d max=%0d exp start=%0d bits=1101010100 width 4",
                     dec_c0, dec_bits[9:0], dec_wmin, dec_wmax, acc2 + 1);
        end
        ones = 0;
        k = (dec_c0 > 0) ? dec_c0 - 1 : 0;
        while (k > 0 && txd_log[k] === 1'b1) begin ones++; k--; end
        total++;
        if (ones !== 5) begin
            bad++;
            $display("FAIL b2b_stop_len got=%0d exp=5", ones);
        end
    endtask

    task automatic test_div_change();
        int acc, acc2, dv_in_frame;
        program_div(8'd0);
        send(8'h3C, 1'b0, 1'b0, acc);
        repeat (8) @(negedge clk);
        program_div(8'd9);
        wait_idle();
        decode(acc, 10, 0);
        total++;
        if (dec_ok !== 1'b1 || dec_bits[9:0] !== 10'b1_0011_1100_0 || dec_wmin !== 2 || dec_wmax !== 2) begin
            bad++;
            $display("FAIL divchg_frame got bits=%b min=%0d max=%0d exp bits=1001111000 width 2",
                     dec_bits[9:0], dec_wmin, dec_wmax);
        end
        dv_in_frame = 0;
        for (int c = acc; c <= dec_end && c >= 0; c++) if (dv_log[c] === 1'b1) dv_in_frame++;
        total++;
        if (dec_end < 0 || dv_in_frame !== 0 || ready_log[dec_end + 1] !== 1'b0 ||
            dv_log[dec_end + 2] !== 1'b1 || div_log[dec_end + 2] !== 8'd9) begin
            bad++;
            $display("FAIL divchg_config got in_frame=%0d ready=%b dv=%b div=%0d exp 0 0 1 9",
                     dv_in_frame, ready_log[dec_end + 1], dv_log[dec_end + 2], div_log[dec_end + 2]);
        end
        send(8'hC3, 1'b0, 1'b0, acc2);
        wait_idle();
        decode(acc2, 10, 0);
        total++;
        if (dec_ok !== 1'b1 || dec_bits[9:0] !== 10'b1_1100_0011_0 || dec_wmin !== 20 || dec_wmax !== 20) begin
            bad++;
            $display("FAIL divchg_next got bits=%b min=%0d max=%0d exp bits=1110000110 width 20",
                     dec_bits[9:0], dec_wmin, dec_wmax);
        end
    endtask

    task automatic test_reset_mid();
        int acc;
        send(8'hF0, 1'b0, 1'b0, acc);
        repeat (60) @(negedge clk);
        total++;
        if (txd !== 1'b0 || tx_busy !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_before got txd=%b busy=%b exp 0 1", txd, tx_busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (txd !== 1'b1 || tx_busy !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_async got txd=%b busy=%b exp 1 0", txd, tx_busy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (gen_div_valid !== 1'b1 || gen_div !== 8'd3) begin
            bad++;
            $display("FAIL rstmid_config got dv=%b div=%0d exp 1 3", gen_div_valid, gen_div);
        end
        send(8'h81, 1'b0, 1'b0, acc);
        wait_idle();
        decode(acc, 10, 0);
        total++;
        if (dec_ok !== 1'b1 || dec_bits[9:0] !== 10'b1_1000_0001_0 || dec_wmin !== 8 || dec_wmax !== 8) begin
            bad++;
            $display("FAIL rstmid_next got bits=%b min=%0d max=%0d exp bits=1100000010 width 8",
                     dec_bits[9:0], dec_wmin, dec_wmax);
        end
    endtask

    initial begin
        test_reset();
        test_a5();
        test_parity();
        test_back_to_back();
        test_div_change();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
